// File: rtl/cpu_pkg.sv
// Shared core definitions: default widths, reset PC, BTB counter encodings
// and an elaboration-time log2 helper.
package cpu_pkg;

   localparam int XLEN_DEF = 32;
   localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } btb_ctr_e;

   function automatic int clog2(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup port, synchronous
// update port with 2-bit saturating counters. Only the valid bits are reset.
module btb_dm
   import cpu_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int DEPTH  = 16,
   parameter bit ENABLE = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] rd_pc,
   output logic            rd_taken,
   output logic [XLEN-1:0] rd_target,
   input  logic            wr_valid,
   input  logic [XLEN-1:0] wr_pc,
   input  logic [XLEN-1:0] wr_target,
   input  logic            wr_taken
);

   localparam int IDX_W = clog2(DEPTH);
   localparam int TAG_W = XLEN - 2 - IDX_W;
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   logic [DEPTH-1:0] valid;
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic [XLEN-1:0]  tgt_mem [DEPTH];
   btb_ctr_e         ctr_mem [DEPTH];

   logic [XLEN-3:0]  rd_word;
   logic [XLEN-3:0]  wr_word;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [TAG_W-1:0] wr_tag;
   logic             rd_hit;
   logic             wr_hit;
   logic             wr_en;
   logic             wr_alloc;

   function automatic btb_ctr_e ctr_step(input btb_ctr_e ctr, input logic taken);
      btb_ctr_e nxt;
      nxt = ctr;
      if (taken && (ctr != ST))
         nxt = btb_ctr_e'(ctr + 2'd1);
      else if (!taken && (ctr != SNT))
         nxt = btb_ctr_e'(ctr - 2'd1);
      return nxt;
   endfunction

   // Word addresses: the byte offset never takes part in index or tag.
   assign rd_word = (XLEN-2)'(rd_pc >> 2);
   assign wr_word = (XLEN-2)'(wr_pc >> 2);
   assign rd_idx  = rd_word[IDX_W-1:0];
   assign rd_tag  = rd_word[XLEN-3:IDX_W];
   assign wr_idx  = wr_word[IDX_W-1:0];
   assign wr_tag  = wr_word[XLEN-3:IDX_W];

   assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
   assign rd_taken  = ENABLE && rd_hit && (ctr_mem[rd_idx] inside {WT, ST});
   assign rd_target = rd_taken ? tgt_mem[rd_idx] : '0;

   assign wr_hit   = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);
   assign wr_en    = ENABLE && wr_valid;
   assign wr_alloc = wr_en && !wr_hit && wr_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         valid <= '0;
      else if (wr_alloc)
         valid[wr_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_hit) begin
            ctr_mem[wr_idx] <= ctr_step(ctr_mem[wr_idx], wr_taken);
            if (wr_taken)
               tgt_mem[wr_idx] <= wr_target & ALIGN_MASK;
         end else if (wr_taken) begin
            tag_mem[wr_idx] <= wr_tag;
            tgt_mem[wr_idx] <= wr_target & ALIGN_MASK;
            ctr_mem[wr_idx] <= WT;
         end
      end
   end

endmodule

// File: rtl/fetch_pc_btb.sv
// Fetch PC register with next-PC priority mux (redirect > stall > predicted
// target > pc+4) and a BTB-based next-PC predictor.
module fetch_pc_btb
   import cpu_pkg::*;
#(
   parameter int              XLEN      = XLEN_DEF,
   parameter int              IMEM_AW   = 9,
   parameter int              BTB_DEPTH = 16,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
   parameter int              PRED_MODE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall_i,
   input  logic               redirect_valid_i,
   input  logic [XLEN-1:0]    redirect_pc_i,
   input  logic               upd_valid_i,
   input  logic [XLEN-1:0]    upd_pc_i,
   input  logic [XLEN-1:0]    upd_target_i,
   input  logic               upd_taken_i,
   output logic [XLEN-1:0]    pc_o,
   output logic [XLEN-1:0]    pc_4_o,
   output logic [IMEM_AW-1:0] imem_addr_o,
   output logic               pred_taken_o,
   output logic [XLEN-1:0]    pred_target_o
);

   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_4;
   logic [XLEN-1:0] next_pc;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;

   btb_dm #(
      .XLEN   (XLEN),
      .DEPTH  (BTB_DEPTH),
      .ENABLE (PRED_MODE != 0)
   ) u_btb (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_pc     (pc_q),
      .rd_taken  (pred_taken),
      .rd_target (pred_target),
      .wr_valid  (upd_valid_i),
      .wr_pc     (upd_pc_i),
      .wr_target (upd_target_i),
      .wr_taken  (upd_taken_i)
   );

   assign pc_4 = pc_q + XLEN'(4);

   always_comb begin
      next_pc = pc_4;
      if (redirect_valid_i)
         next_pc = redirect_pc_i & ALIGN_MASK;
      else if (stall_i)
         next_pc = pc_q;
      else if (pred_taken)
         next_pc = pred_target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc_q <= RESET_PC & ALIGN_MASK;
      else
         pc_q <= next_pc;
   end

   assign pc_o          = pc_q;
   assign pc_4_o        = pc_4;
   assign imem_addr_o   = pc_q[IMEM_AW+1:2];
   assign pred_taken_o  = pred_taken;
   assign pred_target_o = pred_target;

endmodule

// File: tb/tb_fetch_pc_btb.sv
// Bench for fetch_pc_btb: directed steps then randomized traffic, all checked
// against an array-based behavioural model of the fetch unit and its BTB.
module tb_fetch_pc_btb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic [31:0] upd_target_i;
   logic        upd_taken_i;
   logic [31:0] pc_o, pc_4_o, pred_target_o;
   logic [8:0]  imem_addr_o;
   logic        pred_taken_o;
   logic [31:0] s_pc, s_pc_4, s_pred_target;
   logic [8:0]  s_imem_addr;
   logic        s_pred_taken;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_pc, m_pc_s;
   bit          m_valid [16];
   logic [31:0] m_tag [16];
   logic [31:0] m_tgt [16];
   int          m_ctr [16];

   fetch_pc_btb dut (
      .clk (clk), .rst_n (rst_n), .stall_i (stall_i),
      .redirect_valid_i (redirect_valid_i), .redirect_pc_i (redirect_pc_i),
      .upd_valid_i (upd_valid_i), .upd_pc_i (upd_pc_i),
      .upd_target_i (upd_target_i), .upd_taken_i (upd_taken_i),
      .pc_o (pc_o), .pc_4_o (pc_4_o), .imem_addr_o (imem_addr_o),
      .pred_taken_o (pred_taken_o), .pred_target_o (pred_target_o)
   );

   fetch_pc_btb #(.PRED_MODE(0)) dut_static (
      .clk (clk), .rst_n (rst_n), .stall_i (stall_i),
      .redirect_valid_i (redirect_valid_i), .redirect_pc_i (redirect_pc_i),
      .upd_valid_i (upd_valid_i), .upd_pc_i (upd_pc_i),
      .upd_target_i (upd_target_i), .upd_taken_i (upd_taken_i),
      .pc_o (s_pc), .pc_4_o (s_pc_4), .imem_addr_o (s_imem_addr),
      .pred_taken_o (s_pred_taken), .pred_target_o (s_pred_target)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc   = 32'h0;
      m_pc_s = 32'h0;
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
   endtask

   // One clock: drive inputs, check outputs against the model, advance the model.
   task automatic step(input bit st, input bit rv, input logic [31:0] rpc,
                       input bit uv, input logic [31:0] upc,
                       input logic [31:0] utgt, input bit utk);
      int          i, u;
      bit          exp_tk, uhit;
      logic [31:0] exp_tgt, nxt, nxt_s;
      @(negedge clk);
      stall_i = st; redirect_valid_i = rv; redirect_pc_i = rpc;
      upd_valid_i = uv; upd_pc_i = upc; upd_target_i = utgt; upd_taken_i = utk;
      #1;
      i       = int'((m_pc / 4) % 16);
      exp_tk  = m_valid[i] && (m_tag[i] == m_pc / 64) && (m_ctr[i] >= 2);
      exp_tgt = exp_tk ? m_tgt[i] : 32'h0;
      chk("pc", pc_o, m_pc);
      chk("pc_4", pc_4_o, m_pc + 32'd4);
      chk("imem_addr", {23'b0, imem_addr_o}, (m_pc / 4) % 512);
      chk("pred_taken", {31'b0, pred_taken_o}, {31'b0, exp_tk});
      chk("pred_target", pred_target_o, exp_tgt);
      chk("static_pc", s_pc, m_pc_s);
      chk("static_pred_taken", {31'b0, s_pred_taken}, 32'h0);
      chk("static_pred_target", s_pred_target, 32'h0);
      if (rv)          nxt = rpc & ~32'd3;
      else if (st)     nxt = m_pc;
      else if (exp_tk) nxt = exp_tgt;
      else             nxt = m_pc + 32'd4;
      if (rv)          nxt_s = rpc & ~32'd3;
      else if (st)     nxt_s = m_pc_s;
      else             nxt_s = m_pc_s + 32'd4;
      if (uv) begin
         u    = int'((upc / 4) % 16);
         uhit = m_valid[u] && (m_tag[u] == upc / 64);
         if (uhit) begin
            m_ctr[u] = utk ? ((m_ctr[u] < 3) ? m_ctr[u] + 1 : 3)
                           : ((m_ctr[u] > 0) ? m_ctr[u] - 1 : 0);
            if (utk) m_tgt[u] = utgt & ~32'd3;
         end else if (utk) begin
            m_valid[u] = 1'b1;
            m_tag[u]   = upc / 64;
            m_tgt[u]   = utgt & ~32'd3;
            m_ctr[u]   = 2;
         end
      end
      @(posedge clk);
      m_pc   = nxt;
      m_pc_s = nxt_s;
   endtask

   task automatic run();
      step(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
   endtask

   task automatic go(input logic [31:0] a);
      step(0, 1, a, 0, 32'h0, 32'h0, 0);
   endtask

   task automatic upd(input logic [31:0] p, input logic [31:0] t, input bit tk);
      step(0, 0, 32'h0, 1, p, t, tk);
   endtask

   task automatic reset_mid();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_pc", pc_o, 32'h0);
      chk("rst_mid_pred", {31'b0, pred_taken_o}, 32'h0);
      chk("rst_mid_static_pc", s_pc, 32'h0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   function automatic logic [31:0] pool_pc();
      return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
   endfunction

   initial begin
      rst_n = 1'b0;
      stall_i = 0; redirect_valid_i = 0; redirect_pc_i = 0;
      upd_valid_i = 0; upd_pc_i = 0; upd_target_i = 0; upd_taken_i = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      run(); run(); run();
      #1 chk("free_run_pc12", pc_o, 32'hC);
      reset_mid();

      run(); run(); run(); run();
      step(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
      step(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
      #1 chk("stall_hold", pc_o, 32'h10);
      step(1, 1, 32'h80, 0, 32'h0, 32'h0, 0);
      #1 chk("redirect_over_stall", pc_o, 32'h80);
      go(32'h83);
      #1 chk("redirect_align", pc_o, 32'h80);

      upd(32'h20, 32'h100, 1);
      go(32'h20);
      #1 chk("alloc_pred_taken", {31'b0, pred_taken_o}, 32'h1);
      chk("alloc_pred_target", pred_target_o, 32'h100);
      run();
      #1 chk("alloc_next_pc", pc_o, 32'h100);

      upd(32'h20, 32'h0, 0);
      upd(32'h20, 32'h0, 0);
      go(32'h20);
      #1 chk("ctr0_no_pred", {31'b0, pred_taken_o}, 32'h0);
      run();
      #1 chk("ctr0_next_pc", pc_o, 32'h24);

      repeat (4) upd(32'h20, 32'h100, 1);
      upd(32'h20, 32'h0, 0);
      go(32'h20);
      #1 chk("hyst_pred_taken", {31'b0, pred_taken_o}, 32'h1);
      run();
      #1 chk("hyst_next_pc", pc_o, 32'h100);

      upd(32'h60, 32'h200, 1);
      go(32'h20);
      #1 chk("alias_old_miss", {31'b0, pred_taken_o}, 32'h0);
      go(32'h60);
      #1 chk("alias_new_hit", pred_target_o, 32'h200);

      step(0, 0, 32'h0, 1, 32'h60, 32'h300, 0);
      #1 chk("rbw_old_taken", pc_o, 32'h200);
      go(32'h60);
      #1 chk("rbw_new_not_taken", {31'b0, pred_taken_o}, 32'h0);
      go(32'h20);
      step(0, 0, 32'h0, 1, 32'h20, 32'h143, 1);
      #1 chk("rbw_old_miss", pc_o, 32'h24);
      go(32'h20);
      #1 chk("rbw_new_target", pred_target_o, 32'h140);

      go(32'hFFFF_FFFC);
      #1 chk("wrap_pc_4", pc_4_o, 32'h0);
      run();
      #1 chk("wrap_pc", pc_o, 32'h0);

      for (int n = 0; n < 400; n++) begin
         if (n == 200) reset_mid();
         step($urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0,
              pool_pc() | 32'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1,
              pool_pc(),
              ($urandom_range(0, 3) == 0) ? $urandom : pool_pc(),
              $urandom_range(0, 1) == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
